axi_lite_reg_slave: RTL
=======================

// Module: axi_lite_reg_slave
// PURPOSE
//  Parametrised AXI4-Lite slave endpoint: NUM_REGS x DATA_WIDTH register file behind the five AXI4-Lite channels.
//  Accepts AW and W independently in any order; applies byte strobes; returns SLVERR for unmapped addresses.
//  Register contents are exported in parallel for control fabric. Sits behind the interconnect as a leaf slave.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width of awaddr/araddr
//  DATA_WIDTH  32  data width; 32 or 64 only; STRB_WIDTH = DATA_WIDTH/8
//  NUM_REGS    16  number of registers; power of two, >=2; IDX_W = log2(NUM_REGS)
// PORTS
//  aclk      in   1                     clock, all logic on rising edge
//  areset_n  in   1                     reset; asynchronous, active-low
//  awaddr    in   ADDR_WIDTH            write address
//  awvalid   in   1                     write address valid
//  awready   out  1                     write address ready
//  wdata     in   DATA_WIDTH            write data
//  wstrb     in   STRB_WIDTH            write byte strobes
//  wvalid    in   1                     write data valid
//  wready    out  1                     write data ready
//  bresp     out  2                     write response (00 OKAY, 10 SLVERR)
//  bvalid    out  1                     write response valid
//  bready    in   1                     write response ready
//  araddr    in   ADDR_WIDTH            read address
//  arvalid   in   1                     read address valid
//  arready   out  1                     read address ready
//  rdata     out  DATA_WIDTH            read data
//  rresp     out  2                     read response (00 OKAY, 10 SLVERR)
//  rvalid    out  1                     read data valid
//  rready    in   1                     read data ready
//  regs_o    out  NUM_REGS*DATA_WIDTH   register file, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (async, areset_n low): all registers 0; awready/wready/arready 0 while in reset; bvalid/rvalid 0;
//   bresp/rresp/rdata 0; holding flags cleared. Reset mid-transaction drops the transaction; no partial write.
//   First cycle after reset release: awready=wready=arready=1.
//  Decode: ADDR_LSB=log2(STRB_WIDTH); idx=addr[ADDR_LSB +: IDX_W]; mapped iff all bits above
//   ADDR_LSB+IDX_W are 0. Low ADDR_LSB bits ignored.
//  Write path FSM: W_IDLE -> W_COLLECT -> W_RESP.
//   W_IDLE/W_COLLECT: awready=!aw_held, wready=!w_held. Handshake captures addr/data+strb into holding regs.
//   When both held (same cycle or different cycles): commit on the next edge, bvalid=1 that edge, -> W_RESP.
//   So AW+W in the same cycle: commit and bvalid=1 one cycle after the handshake.
//   Commit: mapped -> byte i of reg[idx] updated iff wstrb[i]; bresp=00. Unmapped -> no update; bresp=10.
//   W_RESP: awready=wready=0; bvalid and bresp stable until bready; on bvalid&&bready -> W_IDLE,
//   holds cleared, readies high next cycle. Maximum rate: one write per 3 cycles.
//  Read path FSM: R_IDLE -> R_DATA.
//   R_IDLE: arready=1. On AR handshake: rdata/rresp loaded next edge from the register file as of this
//   cycle, rvalid=1, -> R_DATA. Unmapped -> rdata=0, rresp=10.
//   R_DATA: arready=0; rdata/rresp/rvalid held stable until rready; on rvalid&&rready -> R_IDLE.
//  Read/write independent; an AR handshake in the same cycle as a write commit to the same reg returns the OLD value.
//  regs_o is the register array itself (registered); new value visible the cycle bvalid rises.
//  Valid outputs never depend combinationally on ready inputs; no combinational in->out paths.
// TESTING
//  1 Reset release -> awready=wready=arready=1, bvalid=rvalid=0, regs_o all 0.
//  2 AW+W same cycle, addr 0x08, data 0xDEADBEEF, strb 0xF -> bvalid next cycle, bresp=00; read 0x08 -> rdata=0xDEADBEEF, rresp=00.
//  3 Reg 0x04=0xFFFFFFFF; W (0x12345678, strb 0x3) 2 cycles before AW 0x04 -> wready low after W;
//    bvalid 1 cycle after AW; reg = 0xFFFF5678.
//  4 NUM_REGS=16: write 0x40 -> bresp=10, regs_o unchanged; read 0x40 -> rdata=0, rresp=10.
//  5 bready low 5 cycles -> bvalid/bresp held, awready=0, second AW stalls; rready low 5 cycles -> rdata stable.
//  6 areset_n low while bvalid=1 and rvalid=1 -> both drop immediately (async); regs_o=0.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite leaf slave: NUM_REGS x DATA_WIDTH register file with byte strobes,
// SLVERR on unmapped addresses and a parallel export of every register.
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}            r_state_t;

  // Mapped iff every address bit above the register index is zero.
  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (ADDR_LSB + IDX_W)) == '0;
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t              w_state, w_state_nxt;
  logic                  aw_held, aw_held_nxt;
  logic                  w_held, w_held_nxt;
  logic                  commit;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  aw_mapped_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  r_state_t              r_state, r_state_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Address offset bits below the word size carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  // ---------------- write path ----------------
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = w_state;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    commit      = 1'b0;
    unique case (w_state)
      W_IDLE, W_COLLECT: begin
        if (aw_held && w_held) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end else begin
          if (aw_hs) aw_held_nxt = 1'b1;
          if (w_hs)  w_held_nxt  = 1'b1;
          if (aw_held_nxt || w_held_nxt) w_state_nxt = W_COLLECT;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_nxt = W_IDLE;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Readies are registered from the next state so they stay low through reset
  // and rise on the first edge after release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      awready     <= 1'b0;
      wready      <= 1'b0;
      aw_idx_q    <= '0;
      aw_mapped_q <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      awready <= (w_state_nxt != W_RESP) && !aw_held_nxt;
      wready  <= (w_state_nxt != W_RESP) && !w_held_nxt;
      if (aw_hs) begin
        aw_idx_q    <= awaddr[ADDR_LSB +: IDX_W];
        aw_mapped_q <= addr_mapped(awaddr);
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= aw_mapped_q ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid <= 1'b0;
      end
    end
  end

  // NOTE: the register file is control state exported to fabric, so it is reset like any flop, not left as uninitialised memory.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (commit && aw_mapped_q) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb_q[i]) regs[aw_idx_q][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  // ---------------- read path ----------------
  always_comb begin
    r_state_nxt = r_state;
    if (r_state == R_IDLE) begin
      if (ar_hs) r_state_nxt = R_DATA;
    end else begin
      if (r_hs) r_state_nxt = R_IDLE;
    end
  end

  // rdata samples the array before any same-edge commit lands, so a colliding
  // read returns the old value.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      arready <= (r_state_nxt == R_IDLE);
      if (ar_hs) begin
        rvalid <= 1'b1;
        if (addr_mapped(araddr)) begin
          rdata <= regs[araddr[ADDR_LSB +: IDX_W]];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end else if (r_hs) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule
